// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle control path: opcode classes,
// ALU operation codes, conditional-branch function codes and FSM states.
package kgp_ctrl_pkg;

  // Opcode classes as seen in the IR opcode field
  localparam int OPC_RTYPE = 0;
  localparam int OPC_ADDI  = 1;
  localparam int OPC_COMPI = 2;
  localparam int OPC_SHIFT = 3;
  localparam int OPC_LW    = 4;
  localparam int OPC_SW    = 5;
  localparam int OPC_B     = 6;
  localparam int OPC_BCOND = 7;
  localparam int OPC_HALT  = 8;

  // Codes consumed by the ALU control decoder
  localparam logic [1:0] ALU_OP_RTYPE = 2'd0;
  localparam logic [1:0] ALU_OP_ADD   = 2'd1;
  localparam logic [1:0] ALU_OP_COMP  = 2'd2;
  localparam logic [1:0] ALU_OP_SHIFT = 2'd3;

  // Conditional-branch selectors carried in fn_code
  localparam int BR_FN_BZ   = 0;
  localparam int BR_FN_BNZ  = 1;
  localparam int BR_FN_BLTZ = 2;

  // Main control FSM states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_WB_ALU   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch-taken decision: unconditional branches always taken, conditional
// branches select zero / not-zero / negative from fn_code, anything else not taken.
module branch_cond
  import kgp_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int FN_W  = 5
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [FN_W-1:0]  fn_code,
  input  logic             zero_flag,
  input  logic             sign_flag,
  output logic             taken
);

  // Resolve the taken decision from the branch flavour and ALU flags
  always_comb begin
    taken = 1'b0;
    if (opcode == OPC_W'(OPC_B)) begin
      taken = 1'b1;
    end else if (opcode == OPC_W'(OPC_BCOND)) begin
      if (fn_code == FN_W'(BR_FN_BZ))        taken = zero_flag;
      else if (fn_code == FN_W'(BR_FN_BNZ))  taken = ~zero_flag;
      else if (fn_code == FN_W'(BR_FN_BLTZ)) taken = sign_flag;
      else                                   taken = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the KGP-RISC core. Sequences fetch, decode,
// execute, memory and writeback over a shared ALU, register file and memory port.
// Datapath controls are decoded from the registered state; only the FETCH
// PC/IR strobes additionally look at mem_ready.
module multicycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int FN_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic [FN_W-1:0]  fn_code,
  input  logic             zero_flag,
  input  logic             sign_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             ir_write,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal
);

  state_t     state;
  logic       br_taken;
  logic [1:0] cls_alu_op;
  logic       cls_imm;
  logic       cls_alu;

  branch_cond #(
    .OPC_W (OPC_W),
    .FN_W  (FN_W)
  ) u_branch_cond (
    .opcode    (opcode),
    .fn_code   (fn_code),
    .zero_flag (zero_flag),
    .sign_flag (sign_flag),
    .taken     (br_taken)
  );

  // Classify the ALU-type opcodes: operation code and immediate-operand select
  always_comb begin
    cls_alu_op = ALU_OP_RTYPE;
    cls_imm    = 1'b0;
    cls_alu    = 1'b0;
    if (opcode == OPC_W'(OPC_RTYPE)) begin
      cls_alu = 1'b1;
    end else if (opcode == OPC_W'(OPC_ADDI)) begin
      cls_alu    = 1'b1;
      cls_alu_op = ALU_OP_ADD;
      cls_imm    = 1'b1;
    end else if (opcode == OPC_W'(OPC_COMPI)) begin
      cls_alu    = 1'b1;
      cls_alu_op = ALU_OP_COMP;
      cls_imm    = 1'b1;
    end else if (opcode == OPC_W'(OPC_SHIFT)) begin
      cls_alu    = 1'b1;
      cls_alu_op = ALU_OP_SHIFT;
      cls_imm    = 1'b1;
    end
  end

  // State register and transitions; reset wins over everything, including memory waits
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (cls_alu)                                                    state <= S_EXEC;
          else if (opcode == OPC_W'(OPC_LW) || opcode == OPC_W'(OPC_SW))  state <= S_MEM_ADDR;
          else if (opcode == OPC_W'(OPC_B) || opcode == OPC_W'(OPC_BCOND)) state <= S_BRANCH;
          else if (opcode == OPC_W'(OPC_HALT))                            state <= S_HALT;
          else                                                            state <= S_ILLEGAL;
        end
        S_EXEC:     state <= S_WB_ALU;
        S_WB_ALU:   state <= S_FETCH;
        S_MEM_ADDR: state <= (opcode == OPC_W'(OPC_SW)) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
        S_WB_MEM:   state <= S_FETCH;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_write    = 1'b0;
    pc_branch   = 1'b0;
    ir_write    = 1'b0;
    alu_op      = ALU_OP_RTYPE;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        alu_op      = cls_alu_op;
        alu_src_imm = cls_imm;
      end
      S_WB_ALU: begin
        alu_op      = cls_alu_op;
        alu_src_imm = cls_imm;
        reg_write   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_op      = ALU_OP_ADD;
        alu_src_imm = 1'b1;
      end
      S_MEM_RD: begin
        mem_req     = 1'b1;
        alu_op      = ALU_OP_ADD;
        alu_src_imm = 1'b1;
      end
      S_MEM_WR: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        alu_op      = ALU_OP_ADD;
        alu_src_imm = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_op    = ALU_OP_RTYPE;
        pc_branch = br_taken;
      end
      S_HALT:    halted  = 1'b1;
      S_ILLEGAL: illegal = 1'b1;
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] fn_code;
  logic       zero_flag;
  logic       sign_flag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       pc_write;
  logic       pc_branch;
  logic       ir_write;
  logic [1:0] alu_op;
  logic       alu_src_imm;
  logic       reg_write;
  logic       mem_to_reg;
  logic       halted;
  logic       illegal;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_ctrl #(.OPC_W(6), .FN_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .fn_code     (fn_code),
    .zero_flag   (zero_flag),
    .sign_flag   (sign_flag),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .pc_write    (pc_write),
    .pc_branch   (pc_branch),
    .ir_write    (ir_write),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {req, we, pcw, pcb, irw, aop[1:0], imm, rw, m2r, halted, illegal}
  function automatic logic [11:0] pk(input logic req, input logic we, input logic pcw,
                                     input logic pcb, input logic irw, input logic [1:0] aop,
                                     input logic imm, input logic rw, input logic m2r,
                                     input logic h, input logic il);
    return {req, we, pcw, pcb, irw, aop, imm, rw, m2r, h, il};
  endfunction

  logic [11:0] outs;
  assign outs = {mem_req, mem_we, pc_write, pc_branch, ir_write, alu_op,
                 alu_src_imm, reg_write, mem_to_reg, halted, illegal};

  // Check the current cycle's outputs, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    #1;
    obs = outs;
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  logic [11:0] e_fetch_rdy, e_fetch_wait, e_idle;

  initial begin
    e_fetch_rdy  = pk(1,0,1,0,1,2'd0,0,0,0,0,0);
    e_fetch_wait = pk(1,0,0,0,0,2'd0,0,0,0,0,0);
    e_idle       = pk(0,0,0,0,0,2'd0,0,0,0,0,0);

    rst = 1'b0; opcode = 6'd0; fn_code = 5'd0;
    zero_flag = 1'b0; sign_flag = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step("rst_fetch", e_fetch_wait);
    rst = 1'b1;
    step("fetch_wait", e_fetch_wait);

    // R-type, fn 3, zero-wait memory: 4 cycles
    opcode = 6'd0; fn_code = 5'd3; mem_ready = 1'b1;
    step("r_fetch",  e_fetch_rdy);
    step("r_decode", e_idle);
    step("r_exec",   pk(0,0,0,0,0,2'd0,0,0,0,0,0));
    step("r_wb",     pk(0,0,0,0,0,2'd0,0,1,0,0,0));

    // addi: immediate operand, add
    opcode = 6'd1;
    step("addi_fetch",  e_fetch_rdy);
    step("addi_decode", e_idle);
    step("addi_exec",   pk(0,0,0,0,0,2'd1,1,0,0,0,0));
    step("addi_wb",     pk(0,0,0,0,0,2'd1,1,1,0,0,0));

    // shift-immediate
    opcode = 6'd3;
    step("shi_fetch",  e_fetch_rdy);
    step("shi_decode", e_idle);
    step("shi_exec",   pk(0,0,0,0,0,2'd3,1,0,0,0,0));
    step("shi_wb",     pk(0,0,0,0,0,2'd3,1,1,0,0,0));

    // lw with two wait cycles in MEM_RD: 7 cycles
    opcode = 6'd4;
    step("lw_fetch",  e_fetch_rdy);
    step("lw_decode", e_idle);
    step("lw_addr",   pk(0,0,0,0,0,2'd1,1,0,0,0,0));
    mem_ready = 1'b0;
    step("lw_rd_w1",  pk(1,0,0,0,0,2'd1,1,0,0,0,0));
    step("lw_rd_w2",  pk(1,0,0,0,0,2'd1,1,0,0,0,0));
    mem_ready = 1'b1;
    step("lw_rd_ok",  pk(1,0,0,0,0,2'd1,1,0,0,0,0));
    step("lw_wb",     pk(0,0,0,0,0,2'd0,0,1,1,0,0));

    // sw, zero-wait: 4 cycles, no register write
    opcode = 6'd5;
    step("sw_fetch",  e_fetch_rdy);
    step("sw_decode", e_idle);
    step("sw_addr",   pk(0,0,0,0,0,2'd1,1,0,0,0,0));
    step("sw_wr",     pk(1,1,0,0,0,2'd1,1,0,0,0,0));

    // bz taken
    opcode = 6'd7; fn_code = 5'd0; zero_flag = 1'b1;
    step("bz_t_fetch",  e_fetch_rdy);
    step("bz_t_decode", e_idle);
    step("bz_t_br",     pk(0,0,0,1,0,2'd0,0,0,0,0,0));
    // bz not taken
    zero_flag = 1'b0;
    step("bz_n_fetch",  e_fetch_rdy);
    step("bz_n_decode", e_idle);
    step("bz_n_br",     e_idle);
    // bltz taken
    fn_code = 5'd2; sign_flag = 1'b1;
    step("bltz_fetch",  e_fetch_rdy);
    step("bltz_decode", e_idle);
    step("bltz_br",     pk(0,0,0,1,0,2'd0,0,0,0,0,0));
    // bnz taken with zero clear
    fn_code = 5'd1; sign_flag = 1'b0; zero_flag = 1'b0;
    step("bnz_fetch",  e_fetch_rdy);
    step("bnz_decode", e_idle);
    step("bnz_br",     pk(0,0,0,1,0,2'd0,0,0,0,0,0));
    // undefined condition never taken, even with both flags set
    fn_code = 5'd3; zero_flag = 1'b1; sign_flag = 1'b1;
    step("bund_fetch",  e_fetch_rdy);
    step("bund_decode", e_idle);
    step("bund_br",     e_idle);
    // unconditional branch with flags clear
    opcode = 6'd6; fn_code = 5'd0; zero_flag = 1'b0; sign_flag = 1'b0;
    step("b_fetch",  e_fetch_rdy);
    step("b_decode", e_idle);
    step("b_br",     pk(0,0,0,1,0,2'd0,0,0,0,0,0));

    // halt: sticky for 10 cycles
    opcode = 6'd8;
    step("halt_fetch",  e_fetch_rdy);
    step("halt_decode", e_idle);
    for (int i = 0; i < 10; i++) step("halt_hold", pk(0,0,0,0,0,2'd0,0,0,0,1,0));
    rst = 1'b0;
    step("halt_last", pk(0,0,0,0,0,2'd0,0,0,0,1,0));
    rst = 1'b1; mem_ready = 1'b0;
    step("halt_rst", e_fetch_wait);

    // illegal opcode 63: sticky
    mem_ready = 1'b1; opcode = 6'd63;
    step("ill_fetch",  e_fetch_rdy);
    step("ill_decode", e_idle);
    for (int i = 0; i < 5; i++) step("ill_hold", pk(0,0,0,0,0,2'd0,0,0,0,0,1));
    rst = 1'b0;
    step("ill_last", pk(0,0,0,0,0,2'd0,0,0,0,0,1));
    rst = 1'b1; mem_ready = 1'b0;
    step("ill_rst", e_fetch_wait);

    // reset during a MEM_RD wait
    mem_ready = 1'b1; opcode = 6'd4;
    step("lwr_fetch",  e_fetch_rdy);
    step("lwr_decode", e_idle);
    step("lwr_addr",   pk(0,0,0,0,0,2'd1,1,0,0,0,0));
    mem_ready = 1'b0; rst = 1'b0;
    step("lwr_rd_w",   pk(1,0,0,0,0,2'd1,1,0,0,0,0));
    rst = 1'b1;
    step("lwr_rst",    e_fetch_wait);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the KGP-RISC core; sequences fetch, decode, execute, memory and writeback over one shared ALU, register file and unified memory port.
- Drives the 2-bit alu_op consumed by the ALU control decoder, plus all datapath enables and the memory request handshake.
- Sits between the instruction register (opcode/fn_code fields), the ALU flags and the datapath muxes.

Parameters:
- OPC_W, 6, opcode field width
- FN_W, 5, function-code field width

Ports:
- clk  input  1  core clock, all state changes on rising edge
- rst  input  1  synchronous, active-low reset
- opcode  input  OPC_W  IR opcode field, valid from DECODE onward
- fn_code  input  FN_W  IR function field
- zero_flag  input  1  ALU result == 0
- sign_flag  input  1  ALU result MSB
- mem_ready  input  1  memory completes current request this cycle
- mem_req  output  1  memory request active
- mem_we  output  1  write request (with mem_req)
- pc_write  output  1  load PC with next-sequential value
- pc_branch  output  1  load PC with branch target
- ir_write  output  1  latch instruction word
- alu_op  output  2  to ALU control: 0 R-type/fn_code, 1 add, 2 complement, 3 shift-immediate
- alu_src_imm  output  1  ALU B operand = sign-extended immediate
- reg_write  output  1  register-file write enable
- mem_to_reg  output  1  writeback source = memory data
- halted  output  1  HALT reached
- illegal  output  1  undefined opcode seen

Behaviour:
- States: FETCH, DECODE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT, ILLEGAL.
- Reset (rst==0 at clk edge): state<=FETCH regardless of current state, including mid-memory-wait; halted=0, illegal=0. Combinational outputs follow from FETCH: mem_req=1, all others 0.
- Outputs are decoded from state; exceptions: ir_write and pc_write are asserted in FETCH only in the cycle mem_ready==1.
- FETCH: mem_req=1, mem_we=0; hold until mem_ready==1, then ->DECODE. Minimum 1 cycle.
- DECODE: no enables. Opcode classes:
  - 0 R-type: ->EXEC
  - 1 addi, 2 compi, 3 shift-imm: ->EXEC
  - 4 lw, 5 sw: ->MEM_ADDR
  - 6 b, 7 cond-branch: ->BRANCH
  - 8 halt: ->HALT
  - other: ->ILLEGAL
- EXEC: alu_op = 0/1/2/3 for class 0/1/2/3; alu_src_imm=1 for classes 1-3. ->WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, alu_op held; ->FETCH.
- MEM_ADDR: alu_op=1, alu_src_imm=1. ->MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, mem_we=0, alu_op=1, alu_src_imm=1 held; wait on mem_ready, then ->WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1; ->FETCH.
- MEM_WR: mem_req=1, mem_we=1, address hold as in MEM_RD; wait on mem_ready, then ->FETCH. No reg_write.
- BRANCH: alu_op=0 (rs passes through ALU).
  - Opcode 6: pc_branch=1 unconditionally.
  - Opcode 7, condition from fn_code: 0 bz (zero_flag), 1 bnz (!zero_flag), 2 bltz (sign_flag), other never taken.
  - pc_branch only when taken; ->FETCH.
- HALT: halted=1, all enables 0; sticky until reset.
- ILLEGAL: illegal=1, all enables 0; sticky until reset.
- Mutual exclusion: pc_write and pc_branch never together; reg_write never with mem_req.
- Latency with zero-wait memory:
  - R/imm: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
- Each memory wait cycle adds 1.
- Unencoded state value: next state FETCH.

Decomposition:
- Shared package kgp_ctrl_pkg: opcode class constants, ALU_OP_RTYPE/ADD/COMP/SHIFT, branch fn codes, state encoding (4-bit).
- Optional sub-module branch_cond: combinational taken decision from opcode, fn_code and flags.

Test Plan:
- R-type opcode 0, fn 3, mem_ready always 1 -> FETCH,DECODE,EXEC,WB_ALU; alu_op=0 in EXEC; reg_write=1 only in cycle 4; pc_write/ir_write pulse in cycle 1.
- lw opcode 4, mem_ready low 2 cycles in MEM_RD -> mem_req high 3 cycles, mem_we=0, then WB_MEM with reg_write=1 and mem_to_reg=1; 7 cycles total.
- sw opcode 5, zero-wait memory -> mem_we=1 with mem_req in MEM_WR, reg_write never asserted, back to FETCH after 4 cycles.
- Branch opcode 7, fn 0:
  - zero_flag=1 -> pc_branch=1 in BRANCH.
  - Repeat with zero_flag=0 -> pc_branch=0.
  - fn 2 with sign_flag=1 -> pc_branch=1.
- Opcode 8 -> halted=1 and held across 10 cycles. Opcode 63 -> illegal=1, all enables 0 and held.
- rst=0 asserted during a MEM_RD wait -> next edge state FETCH, mem_req=1, mem_we=0, halted=0, illegal=0.
